// File: rtl/rvc_packer_if.sv
// Instruction-in / packed-word-out bus of the RVC packer.
// The packer uses the slave modport; the instruction producer uses master.
interface rvc_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        in_flush;
  logic        flush_ack;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic [15:0] comp_cnt;

  modport master (
    output in_valid, in_instr, in_flush, out_ready,
    input  in_ready, flush_ack, out_valid, out_word, out_addr, comp_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_flush, out_ready,
    output in_ready, flush_ack, out_valid, out_word, out_addr, comp_cnt
  );
endinterface

// File: rtl/rvc_packer.sv
// Compresses a subset of RV32I into RVC and packs halfwords into 32-bit memory
// words in the byte order the fetch-side realigner expects.
module rvc_packer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          COMPRESS_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  rvc_packer_if.slave  bus
);

  // Returns {valid, rvc}; valid=0 means the instruction stays 32-bit.
  function automatic logic [16:0] rvc_compress(input logic [31:0] i);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic        imm6_ok;
    logic        is_addi;
    logic        is_add;
    logic [16:0] res;
    op      = i[6:0];
    f3      = i[14:12];
    rd      = i[11:7];
    rs1     = i[19:15];
    rs2     = i[24:20];
    imm_i   = i[31:20];
    imm_s   = {i[31:25], i[11:7]};
    imm6_ok = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7F);
    is_addi = (op == 7'h13) && (f3 == 3'b000);
    is_add  = (op == 7'h33) && (f3 == 3'b000) && (i[31:25] == 7'h00);
    if (is_addi && (rd == 5'd0) && (rs1 == 5'd0) && (imm_i == 12'd0)) begin
      res = {1'b1, 16'h0001};
    end else if (is_addi && (rd != 5'd0) && (rs1 == 5'd0) && imm6_ok) begin
      res = {1'b1, 3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
    end else if (is_addi && (rd != 5'd0) && (rs1 == rd) && (imm_i != 12'd0) && imm6_ok) begin
      res = {1'b1, 3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
    end else if (is_addi && (rd != 5'd0) && (rs1 != 5'd0) && (rd != rs1) && (imm_i == 12'd0)) begin
      res = {1'b1, 4'b1000, rd, rs1, 2'b10};
    end else if (is_add && (rd != 5'd0) && (rs1 == 5'd0) && (rs2 != 5'd0)) begin
      res = {1'b1, 4'b1000, rd, rs2, 2'b10};
    end else if (is_add && (rd != 5'd0) && (rs1 == rd) && (rs2 != 5'd0)) begin
      res = {1'b1, 4'b1001, rd, rs2, 2'b10};
    end else if ((op == 7'h03) && (f3 == 3'b010) && (rd[4:3] == 2'b01) && (rs1[4:3] == 2'b01)
                 && (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00)) begin
      res = {1'b1, 3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
    end else if ((op == 7'h23) && (f3 == 3'b010) && (rs2[4:3] == 2'b01) && (rs1[4:3] == 2'b01)
                 && (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00)) begin
      res = {1'b1, 3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
    end else begin
      res = 17'h0_0000;
    end
    return res;
  endfunction

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_word_q,  out_word_d;
  logic [31:0] out_addr_q,  out_addr_d;
  logic        pend_q,      pend_d;
  logic [15:0] pend_half_q, pend_half_d;
  logic [15:0] comp_cnt_q,  comp_cnt_d;

  logic        in_ready_s;
  logic        accept_s;
  logic        flush_take_s;
  logic [16:0] c_res_s;
  logic        emit_s;
  logic [15:0] h0_s;
  logic [15:0] h1_s;

  assign in_ready_s   = !out_valid_q || bus.out_ready;
  assign accept_s     = bus.in_valid && in_ready_s;
  assign flush_take_s = !rst && bus.in_flush && !bus.in_valid && in_ready_s;
  assign c_res_s      = COMPRESS_EN ? rvc_compress(bus.in_instr) : 17'h0_0000;

  assign bus.in_ready  = in_ready_s;
  assign bus.flush_ack = flush_take_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.comp_cnt  = comp_cnt_q;

  always_comb begin
    out_valid_d = out_valid_q && !bus.out_ready;
    out_word_d  = out_word_q;
    pend_d      = pend_q;
    pend_half_d = pend_half_q;
    comp_cnt_d  = comp_cnt_q;
    emit_s      = 1'b0;
    h0_s        = 16'h0000;
    h1_s        = 16'h0000;
    if (out_valid_q && bus.out_ready) begin
      out_addr_d = out_addr_q + 32'd4;
    end else begin
      out_addr_d = out_addr_q;
    end
    if (accept_s) begin
      if (c_res_s[16]) begin
        comp_cnt_d = comp_cnt_q + 16'd1;
        if (pend_q) begin
          emit_s = 1'b1;
          h0_s   = pend_half_q;
          h1_s   = c_res_s[15:0];
          pend_d = 1'b0;
        end else begin
          pend_half_d = c_res_s[15:0];
          pend_d      = 1'b1;
        end
      end else begin
        // A 32-bit instruction behind a pending half straddles two words.
        emit_s = 1'b1;
        if (pend_q) begin
          h0_s        = pend_half_q;
          h1_s        = bus.in_instr[15:0];
          pend_half_d = bus.in_instr[31:16];
        end else begin
          h0_s = bus.in_instr[15:0];
          h1_s = bus.in_instr[31:16];
        end
      end
    end else if (flush_take_s) begin
      if (pend_q) begin
        emit_s = 1'b1;
        h0_s   = pend_half_q;
        h1_s   = 16'h0001;
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b0;
      end
    end else begin
      pend_d = pend_q;
    end
    if (emit_s) begin
      out_valid_d = 1'b1;
      out_word_d  = {h0_s[7:0], h0_s[15:8], h1_s[7:0], h1_s[15:8]};
    end else begin
      out_word_d = out_word_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_word_q  <= 32'h0000_0000;
      out_addr_q  <= BASE_ADDR;
      pend_q      <= 1'b0;
      pend_half_q <= 16'h0000;
      comp_cnt_q  <= 16'h0000;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      pend_q      <= pend_d;
      pend_half_q <= pend_half_d;
      comp_cnt_q  <= comp_cnt_d;
    end
  end

endmodule

// File: tb/tb_rvc_packer.sv
// Randomized bench for rvc_packer against a halfword-stream reference model.
module tb_rvc_packer;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rvc_packer_if bus_if ();

  rvc_packer #(.BASE_ADDR(BASE), .COMPRESS_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] hq[$];
  logic [31:0] wq[$];
  logic [31:0] m_addr;
  logic [15:0] m_cnt;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference compressor: {valid, rvc}, written from the encoding rules.
  function automatic logic [16:0] ref_c(input logic [31:0] i);
    logic [4:0] rd, rs1, rs2;
    logic [6:0] u;
    logic [5:0] b;
    int imm, simm;
    rd   = i[11:7];
    rs1  = i[19:15];
    rs2  = i[24:20];
    imm  = int'($signed(i[31:20]));
    simm = int'($signed({i[31:25], i[11:7]}));
    if (i[6:0] == 7'h13 && i[14:12] == 3'd0) begin
      b = imm[5:0];
      if (rd == 0 && rs1 == 0 && imm == 0) return {1'b1, 16'h0001};
      if (rd != 0 && rs1 == 0 && imm >= -32 && imm <= 31)
        return {1'b1, 3'b010, b[5], rd, b[4:0], 2'b01};
      if (rd != 0 && rs1 == rd && imm != 0 && imm >= -32 && imm <= 31)
        return {1'b1, 3'b000, b[5], rd, b[4:0], 2'b01};
      if (rd != 0 && rs1 != 0 && rd != rs1 && imm == 0)
        return {1'b1, 4'b1000, rd, rs1, 2'b10};
    end
    if (i[6:0] == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'd0) begin
      if (rd != 0 && rs1 == 0 && rs2 != 0) return {1'b1, 4'b1000, rd, rs2, 2'b10};
      if (rd != 0 && rs1 == rd && rs2 != 0) return {1'b1, 4'b1001, rd, rs2, 2'b10};
    end
    if (i[6:0] == 7'h03 && i[14:12] == 3'd2 && rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15
        && imm >= 0 && imm <= 124 && (imm % 4) == 0) begin
      u = imm[6:0];
      return {1'b1, 3'b010, u[5:3], rs1[2:0], u[2], u[6], rd[2:0], 2'b00};
    end
    if (i[6:0] == 7'h23 && i[14:12] == 3'd2 && rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15
        && simm >= 0 && simm <= 124 && (simm % 4) == 0) begin
      u = simm[6:0];
      return {1'b1, 3'b110, u[5:3], rs1[2:0], u[2], u[6], rs2[2:0], 2'b00};
    end
    return 17'h0_0000;
  endfunction

  // Memory is little-endian by halfword; word MSB byte is the lowest address.
  task automatic drain_halves();
    logic [7:0]  bytes[4];
    logic [15:0] h;
    logic [31:0] w;
    while (hq.size() >= 2) begin
      for (int k = 0; k < 2; k++) begin
        h = hq.pop_front();
        bytes[2*k]   = h[7:0];
        bytes[2*k+1] = h[15:8];
      end
      w = 32'h0;
      for (int k = 0; k < 4; k++) w = (w << 8) | {24'h0, bytes[k]};
      wq.push_back(w);
    end
  endtask

  task automatic run_cycle(input logic v, input logic [31:0] instr, input logic fl, input logic ordy);
    logic exp_rdy, take;
    logic [16:0] cr;
    @(negedge clk);
    bus_if.in_valid  = v;
    bus_if.in_instr  = instr;
    bus_if.in_flush  = fl;
    bus_if.out_ready = ordy;
    #1;
    exp_rdy = (wq.size() == 0) || ordy;
    take    = fl && !v && exp_rdy;
    chk_val("in_ready", {31'h0, bus_if.in_ready}, {31'h0, exp_rdy});
    chk_val("out_valid", {31'h0, bus_if.out_valid}, {31'h0, wq.size() != 0});
    if (wq.size() != 0) begin
      chk_val("out_word", bus_if.out_word, wq[0]);
      chk_val("out_addr", bus_if.out_addr, m_addr);
    end
    chk_val("comp_cnt", {16'h0, bus_if.comp_cnt}, {16'h0, m_cnt});
    chk_val("flush_ack", {31'h0, bus_if.flush_ack}, {31'h0, take});
    if (wq.size() != 0 && ordy) begin
      void'(wq.pop_front());
      m_addr += 32'd4;
    end
    if (v && exp_rdy) begin
      cr = ref_c(instr);
      if (cr[16]) begin
        hq.push_back(cr[15:0]);
        m_cnt += 16'd1;
      end else begin
        hq.push_back(instr[15:0]);
        hq.push_back(instr[31:16]);
      end
      drain_halves();
    end else if (take && hq.size() == 1) begin
      hq.push_back(16'h0001);
      drain_halves();
    end
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_flush  = 1'b0;
    bus_if.in_instr  = 32'h0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk_val("rst_out_valid", {31'h0, bus_if.out_valid}, 32'h0);
    chk_val("rst_out_word", bus_if.out_word, 32'h0);
    chk_val("rst_out_addr", bus_if.out_addr, BASE);
    chk_val("rst_comp_cnt", {16'h0, bus_if.comp_cnt}, 32'h0);
    chk_val("rst_flush_ack", {31'h0, bus_if.flush_ack}, 32'h0);
    chk_val("rst_in_ready", {31'h0, bus_if.in_ready}, 32'h1);
    rst = 1'b0;
    hq.delete();
    wq.delete();
    m_addr = BASE;
    m_cnt  = 16'h0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [6:0]  f7;
    int k;
    rd  = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 3))
      0:       rs1 = 5'd0;
      1:       rs1 = rd;
      default: rs1 = 5'($urandom_range(0, 31));
    endcase
    case ($urandom_range(0, 5))
      0:       imm = 12'd0;
      1:       imm = 12'hFE0;
      2:       imm = 12'd31;
      3:       imm = 12'd32;
      4:       imm = 12'hFDF;
      default: imm = 12'($urandom_range(0, 4095));
    endcase
    k = $urandom_range(0, 6);
    if (k == 2 || k == 3) begin
      rd  = 5'($urandom_range(6, 17));
      rs1 = 5'($urandom_range(6, 17));
      rs2 = 5'($urandom_range(6, 17));
      case ($urandom_range(0, 5))
        0:       imm = 12'd0;
        1:       imm = 12'd124;
        2:       imm = 12'd128;
        3:       imm = 12'hFFC;
        4:       imm = 12'($urandom_range(0, 35) * 4);
        default: imm = 12'($urandom_range(0, 130));
      endcase
    end
    f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
    case (k)
      0:       return {imm, rs1, 3'b000, rd, 7'h13};
      1:       return {f7, rs2, rs1, 3'b000, rd, 7'h33};
      2:       return {imm, rs1, 3'b010, rd, 7'h03};
      3:       return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
      4:       return 32'h0000_0013;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_flush  = 1'b0;
    bus_if.in_instr  = 32'h0;
    bus_if.out_ready = 1'b1;
    m_addr = BASE;
    m_cnt  = 16'h0;

    // Two compressible instructions share one word.
    do_reset();
    run_cycle(1'b1, 32'h0050_8093, 1'b0, 1'b1);
    run_cycle(1'b1, 32'hFFF0_0113, 1'b0, 1'b1);
    peek();
    chk_val("pair_word", bus_if.out_word, 32'h9500_7D51);
    chk_val("pair_addr", bus_if.out_addr, BASE);
    chk_val("pair_cnt", {16'h0, bus_if.comp_cnt}, 32'd2);

    do_reset();
    run_cycle(1'b1, 32'h0000_006F, 1'b0, 1'b1);
    peek();
    chk_val("aligned_word", bus_if.out_word, 32'h6F00_0000);

    // Straddling 32-bit instruction, then flush pads with C.NOP.
    do_reset();
    run_cycle(1'b1, 32'h0000_0013, 1'b0, 1'b1);
    run_cycle(1'b1, 32'h1234_52B7, 1'b0, 1'b1);
    peek();
    chk_val("straddle_word", bus_if.out_word, 32'h0100_B752);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    peek();
    chk_val("flush_word", bus_if.out_word, 32'h3412_0100);
    chk_val("flush_addr", bus_if.out_addr, BASE + 32'd4);

    do_reset();
    run_cycle(1'b1, 32'h0044_A403, 1'b0, 1'b1);
    run_cycle(1'b1, 32'h0641_0093, 1'b0, 1'b1);
    peek();
    chk_val("lw_word", bus_if.out_word, 32'hC040_9300);
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    peek();
    chk_val("lw_tail_word", bus_if.out_word, 32'h4106_0100);

    // Backpressure for five cycles, then release.
    do_reset();
    run_cycle(1'b1, 32'h0000_006F, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) run_cycle(1'b1, 32'h0010_0093, 1'b0, 1'b0);
    run_cycle(1'b1, 32'h0010_0093, 1'b0, 1'b1);
    run_cycle(1'b1, 32'h0020_0113, 1'b0, 1'b1);
    peek();
    chk_val("bp_word", bus_if.out_word, 32'h8540_0941);
    chk_val("bp_addr", bus_if.out_addr, BASE + 32'd4);

    // Reset discards the pending half; a later flush emits nothing.
    do_reset();
    run_cycle(1'b1, 32'h0000_0013, 1'b0, 1'b1);
    do_reset();
    run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    peek();
    chk_val("rstpend_valid", {31'h0, bus_if.out_valid}, 32'h0);
    chk_val("rstpend_addr", bus_if.out_addr, BASE);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        run_cycle($urandom_range(0, 3) != 0, gen_instr(),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      end
    end
    for (int n = 0; n < 4; n++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
